// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   localparam int ENTRY_W = 10;

   function automatic logic prescale_legal(input logic [5:0] p);
      return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO for received frames; no write-to-read bypass, so data
// written into an empty FIFO becomes visible one cycle later.
module uart_rx_ctrl_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             wr_s;
   logic             rd_s;

   // A full FIFO still accepts a write when the same cycle pops the head.
   always_comb begin
      rd_s        = rd_en && !empty_r;
      wr_s        = wr_en && (!full_r || rd_s);
      count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, wr_s} - {{(CNT_W-1){1'b0}}, rd_s};
   end

   // Storage, pointers and registered status flags.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_W'(DEPTH));
         empty_r <= (count_nxt_s == {CNT_W{1'b0}});
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign full    = full_r;
   assign empty   = empty_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame-boundary config commit plus frame FIFO.
// Optional error counters are built when UART_RX_ERR_CNT_EN is defined.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int DEF_PRESCALE = 8,
   parameter int DROP_ERR     = 0
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         cfg_req,
   input  logic [5:0]   cfg_prescale,
   input  logic         cfg_par_en,
   input  logic         cfg_par_typ,
   output logic         cfg_ack,
   output logic         cfg_err,
   output logic         cfg_busy,
   input  logic         rx_busy,
   input  logic         rx_frame_done,
   input  logic [7:0]   rx_p_data,
   input  logic         rx_par_err,
   input  logic         rx_stp_err,
   output logic         rx_en,
   output logic [5:0]   rx_prescale,
   output logic         rx_par_en,
   output logic         rx_par_typ,
   output logic [9:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         ovf,
   input  logic         ovf_clr,
   output logic [7:0]   par_err_cnt,
   output logic [7:0]   stp_err_cnt,
   input  logic         cnt_clr
);

   state_t               state_r;
   logic [5:0]           sh_prescale_r;
   logic                 sh_par_en_r;
   logic                 sh_par_typ_r;
   logic                 cfg_ack_r;
   logic                 cfg_err_r;
   logic                 cfg_busy_r;
   logic                 rx_en_r;
   logic [5:0]           rx_prescale_r;
   logic                 rx_par_en_r;
   logic                 rx_par_typ_r;
   logic                 ovf_r;
   logic                 push_s;
   logic                 pop_s;
   logic                 ovf_set_s;
   logic                 full_s;
   logic                 empty_s;
   logic [ENTRY_W-1:0]   entry_s;

   // Errored frames are filtered before the full check when DROP_ERR is set.
   always_comb begin
      entry_s = {rx_par_err, rx_stp_err, rx_p_data};
      if ((DROP_ERR != 0) && (rx_par_err || rx_stp_err)) begin
         push_s = 1'b0;
      end else begin
         push_s = rx_frame_done;
      end
      pop_s     = out_ready && !empty_s;
      ovf_set_s = push_s && full_s && !pop_s;
   end

   uart_rx_ctrl_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (push_s),
      .wr_data (entry_s),
      .rd_en   (out_ready),
      .rd_data (out_data),
      .full    (full_s),
      .empty   (empty_s)
   );

   // Config FSM; outputs are registered so each reflects the state it is in.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r       <= ST_RUN;
         sh_prescale_r <= 6'(DEF_PRESCALE);
         sh_par_en_r   <= 1'b0;
         sh_par_typ_r  <= 1'b0;
         cfg_ack_r     <= 1'b0;
         cfg_err_r     <= 1'b0;
         cfg_busy_r    <= 1'b0;
         rx_en_r       <= 1'b1;
         rx_prescale_r <= 6'(DEF_PRESCALE);
         rx_par_en_r   <= 1'b0;
         rx_par_typ_r  <= 1'b0;
      end else begin
         cfg_ack_r <= 1'b0;
         cfg_err_r <= 1'b0;
         case (state_r)
            ST_RUN: begin
               if (cfg_req) begin
                  if (prescale_legal(cfg_prescale)) begin
                     sh_prescale_r <= cfg_prescale;
                     sh_par_en_r   <= cfg_par_en;
                     sh_par_typ_r  <= cfg_par_typ;
                     state_r       <= ST_DRAIN;
                     rx_en_r       <= 1'b0;
                     cfg_busy_r    <= 1'b1;
                  end else begin
                     cfg_err_r <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (!rx_busy) begin
                  state_r       <= ST_APPLY;
                  rx_prescale_r <= sh_prescale_r;
                  rx_par_en_r   <= sh_par_en_r;
                  rx_par_typ_r  <= sh_par_typ_r;
                  cfg_ack_r     <= 1'b1;
               end
            end
            ST_APPLY: begin
               state_r    <= ST_RUN;
               rx_en_r    <= 1'b1;
               cfg_busy_r <= 1'b0;
            end
            default: begin
               state_r    <= ST_RUN;
               rx_en_r    <= 1'b1;
               cfg_busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overflow; a new overflow beats a simultaneous clear.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
         ovf_r <= 1'b1;
      end else if (ovf_clr) begin
         ovf_r <= 1'b0;
      end
   end

`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] par_cnt_r;
   logic [7:0] stp_cnt_r;

   // Saturating error counters; clear wins over increment.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         par_cnt_r <= 8'd0;
         stp_cnt_r <= 8'd0;
      end else if (cnt_clr) begin
         par_cnt_r <= 8'd0;
         stp_cnt_r <= 8'd0;
      end else begin
         if (rx_frame_done && rx_par_err && (par_cnt_r != 8'hFF)) par_cnt_r <= par_cnt_r + 8'd1;
         if (rx_frame_done && rx_stp_err && (stp_cnt_r != 8'hFF)) stp_cnt_r <= stp_cnt_r + 8'd1;
      end
   end

   assign par_err_cnt = par_cnt_r;
   assign stp_err_cnt = stp_cnt_r;
`else
   logic cnt_clr_unused_s;
   assign cnt_clr_unused_s = cnt_clr;
   assign par_err_cnt      = 8'd0;
   assign stp_err_cnt      = 8'd0;
`endif

   assign cfg_ack     = cfg_ack_r;
   assign cfg_err     = cfg_err_r;
   assign cfg_busy    = cfg_busy_r;
   assign rx_en       = rx_en_r;
   assign rx_prescale = rx_prescale_r;
   assign rx_par_en   = rx_par_en_r;
   assign rx_par_typ  = rx_par_typ_r;
   assign out_valid   = !empty_s;
   assign ovf         = ovf_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (DEPTH=4, DEF_PRESCALE=8, DROP_ERR=0).
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       cfg_req = 1'b0;
   logic [5:0] cfg_prescale = 6'd0;
   logic       cfg_par_en = 1'b0;
   logic       cfg_par_typ = 1'b0;
   logic       cfg_ack, cfg_err, cfg_busy;
   logic       rx_busy = 1'b0;
   logic       rx_frame_done = 1'b0;
   logic [7:0] rx_p_data = 8'd0;
   logic       rx_par_err = 1'b0;
   logic       rx_stp_err = 1'b0;
   logic       rx_en;
   logic [5:0] rx_prescale;
   logic       rx_par_en, rx_par_typ;
   logic [9:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       ovf;
   logic       ovf_clr = 1'b0;
   logic [7:0] par_err_cnt, stp_err_cnt;
   logic       cnt_clr = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   uart_rx_ctrl #(.DEPTH(4), .DEF_PRESCALE(8), .DROP_ERR(0)) dut (
      .CLK(CLK), .RST(RST),
      .cfg_req(cfg_req), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
      .cfg_par_typ(cfg_par_typ), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .cfg_busy(cfg_busy),
      .rx_busy(rx_busy), .rx_frame_done(rx_frame_done), .rx_p_data(rx_p_data),
      .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .rx_en(rx_en),
      .rx_prescale(rx_prescale), .rx_par_en(rx_par_en), .rx_par_typ(rx_par_typ),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .ovf(ovf), .ovf_clr(ovf_clr), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt),
      .cnt_clr(cnt_clr)
   );

   typedef struct {
      logic       req;  logic [5:0] pre; logic pen; logic ptyp;
      logic       busy; logic done; logic [7:0] data; logic perr; logic serr; logic rdy;
      logic       e_ack; logic e_err; logic e_cbusy; logic e_en;
      logic [5:0] e_pre; logic e_pen; logic e_ptyp; logic e_valid; logic [9:0] e_data;
   } vec_t;

   localparam int NV = 16;
   vec_t vec [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_frame(input logic [7:0] d, input logic pe, input logic se, input logic rdy);
      rx_frame_done = 1'b1; rx_p_data = d; rx_par_err = pe; rx_stp_err = se; out_ready = rdy;
      tick();
      rx_frame_done = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0; out_ready = 1'b0;
   endtask

   task automatic pop_expect(input string nm, input logic [9:0] d);
      chk({nm, "_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_data"}, 32'(out_data), 32'(d));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      // req pre pen ptyp busy done data perr serr rdy | ack err cbusy en pre pen ptyp valid data
      vec[0]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd8,  1'b0, 1'b0, 1'b0, 10'h000};
      vec[1]  = '{1'b1, 6'd12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b0, 1'b1, 6'd8,  1'b0, 1'b0, 1'b0, 10'h000};
      vec[2]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd8,  1'b0, 1'b0, 1'b0, 10'h000};
      vec[3]  = '{1'b1, 6'd16, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 6'd8,  1'b0, 1'b0, 1'b0, 10'h000};
      vec[4]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b0, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1, 1'b0, 10'h000};
      vec[5]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd16, 1'b1, 1'b1, 1'b0, 10'h000};
      vec[6]  = '{1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b0, 1'b1, 6'd16, 1'b1, 1'b1, 1'b0, 10'h000};
      vec[7]  = '{1'b1, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1, 1'b0, 10'h000};
      vec[8]  = '{1'b1, 6'd8,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1, 1'b0, 10'h000};
      vec[9]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b0, 1'b1, 1'b0, 6'd32, 1'b0, 1'b0, 1'b0, 10'h000};
      vec[10] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0, 10'h000};
      vec[11] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, 1'b0, 1'b1, 10'h23C};
      vec[12] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0, 10'h000};
      vec[13] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, 1'b0, 1'b1, 10'h15A};
      vec[14] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, 1'b0, 1'b1, 10'h15A};
      vec[15] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0, 10'h000};

      // Reset values
      #12;
      chk("rst_en", 32'(rx_en), 32'd1);
      chk("rst_pre", 32'(rx_prescale), 32'd8);
      chk("rst_busy", 32'(cfg_busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      RST = 1'b1;
      tick();

      for (int i = 0; i < NV; i++) begin
         cfg_req = vec[i].req; cfg_prescale = vec[i].pre;
         cfg_par_en = vec[i].pen; cfg_par_typ = vec[i].ptyp;
         rx_busy = vec[i].busy; rx_frame_done = vec[i].done; rx_p_data = vec[i].data;
         rx_par_err = vec[i].perr; rx_stp_err = vec[i].serr; out_ready = vec[i].rdy;
         tick();
         chk($sformatf("v%0d_ack", i), 32'(cfg_ack), 32'(vec[i].e_ack));
         chk($sformatf("v%0d_err", i), 32'(cfg_err), 32'(vec[i].e_err));
         chk($sformatf("v%0d_cbusy", i), 32'(cfg_busy), 32'(vec[i].e_cbusy));
         chk($sformatf("v%0d_en", i), 32'(rx_en), 32'(vec[i].e_en));
         chk($sformatf("v%0d_pre", i), 32'(rx_prescale), 32'(vec[i].e_pre));
         chk($sformatf("v%0d_pen", i), 32'(rx_par_en), 32'(vec[i].e_pen));
         chk($sformatf("v%0d_ptyp", i), 32'(rx_par_typ), 32'(vec[i].e_ptyp));
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vec[i].e_valid));
         if (vec[i].e_valid) chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vec[i].e_data));
      end
      cfg_req = 1'b0; rx_frame_done = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0; out_ready = 1'b0;

      // Config request while a frame is in flight
      cfg_req = 1'b1; cfg_prescale = 6'd16; rx_busy = 1'b1;
      tick();
      cfg_req = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cfg_req = (i == 20); cfg_prescale = 6'd8;
         rx_frame_done = (i == 39); rx_p_data = 8'hA5;
         tick();
         chk($sformatf("drain%0d_en", i), 32'(rx_en), 32'd0);
         chk($sformatf("drain%0d_cbusy", i), 32'(cfg_busy), 32'd1);
      end
      cfg_req = 1'b0; rx_frame_done = 1'b0; rx_busy = 1'b0;
      tick();
      chk("drain_ack", 32'(cfg_ack), 32'd1);
      chk("drain_pre", 32'(rx_prescale), 32'd16);
      pop_expect("drain_a5", 10'h0A5);
      chk("drain_en_back", 32'(rx_en), 32'd1);
      chk("drain_ack_off", 32'(cfg_ack), 32'd0);

      // Overflow: five frames into a four-deep FIFO; fifth drop coincides with ovf_clr
      for (int k = 1; k <= 4; k++) push_frame(8'(k), 1'b0, 1'b0, 1'b0);
      chk("full_ovf0", 32'(ovf), 32'd0);
      ovf_clr = 1'b1;
      push_frame(8'h05, 1'b0, 1'b0, 1'b0);
      ovf_clr = 1'b0;
      chk("ovf_set_wins", 32'(ovf), 32'd1);
      tick();
      chk("ovf_sticky", 32'(ovf), 32'd1);
      for (int k = 1; k <= 4; k++) pop_expect($sformatf("ovf_pop%0d", k), 10'(k));
      chk("ovf_empty", 32'(out_valid), 32'd0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(ovf), 32'd0);

      // Full FIFO with simultaneous push and pop
      for (int k = 1; k <= 4; k++) push_frame(8'(k), 1'b0, 1'b0, 1'b0);
      push_frame(8'h77, 1'b0, 1'b0, 1'b1);
      chk("pp_ovf", 32'(ovf), 32'd0);
      pop_expect("pp_pop2", 10'h002);
      pop_expect("pp_pop3", 10'h003);
      pop_expect("pp_pop4", 10'h004);
      pop_expect("pp_pop77", 10'h077);
      chk("pp_empty", 32'(out_valid), 32'd0);

`ifdef UART_RX_ERR_CNT_EN
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk("cnt_clr0_par", 32'(par_err_cnt), 32'd0);
      chk("cnt_clr0_stp", 32'(stp_err_cnt), 32'd0);
      for (int k = 0; k < 3; k++) push_frame(8'h10, 1'b1, 1'b0, 1'b1);
      push_frame(8'h11, 1'b0, 1'b1, 1'b1);
      chk("cnt_par3", 32'(par_err_cnt), 32'd3);
      chk("cnt_stp1", 32'(stp_err_cnt), 32'd1);
      for (int k = 0; k < 260; k++) push_frame(8'h12, 1'b1, 1'b0, 1'b1);
      chk("cnt_par_sat", 32'(par_err_cnt), 32'd255);
      chk("cnt_stp_keep", 32'(stp_err_cnt), 32'd1);
      cnt_clr = 1'b1;
      push_frame(8'h13, 1'b1, 1'b1, 1'b1);
      cnt_clr = 1'b0;
      chk("cnt_clr_par", 32'(par_err_cnt), 32'd0);
      chk("cnt_clr_stp", 32'(stp_err_cnt), 32'd0);
`else
      push_frame(8'h10, 1'b1, 1'b1, 1'b1);
      chk("nocnt_par", 32'(par_err_cnt), 32'd0);
      chk("nocnt_stp", 32'(stp_err_cnt), 32'd0);
`endif
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Reset in the middle of DRAIN discards the pending request
      cfg_req = 1'b1; cfg_prescale = 6'd16; rx_busy = 1'b1;
      tick();
      cfg_req = 1'b0;
      chk("rd_busy", 32'(cfg_busy), 32'd1);
      tick();
      #2 RST = 1'b0;
      #1;
      chk("rd_pre", 32'(rx_prescale), 32'd8);
      chk("rd_en", 32'(rx_en), 32'd1);
      chk("rd_cbusy", 32'(cfg_busy), 32'd0);
      rx_busy = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      tick();
      tick();
      chk("rd_noack", 32'(cfg_ack), 32'd0);
      chk("rd_pre_after", 32'(rx_prescale), 32'd8);
      chk("rd_pen_after", 32'(rx_par_en), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
